forward_hazard_unit: RTL and testbench
======================================

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 Parameter NUM_SRC, default 2, number of forwarding sources; index 0 is the youngest (EX/MEM), ascending index is older.
REQ-002 Parameter NUM_RS, default 2, number of source-register read ports per instruction.
REQ-003 Parameter REG_AW, default 5, register address width.
REQ-004 Parameter LOAD_LAT, default 1, range 1..15, stall cycles required per load-use hazard.
REQ-005 Derived constant SELW = clog2(NUM_SRC+1), width of one forwarding select.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous and active-low.
REQ-008 rs_ex  in  NUM_RS*REG_AW  source registers of the instruction in EX; port p is in slice p.
REQ-009 src_we  in  NUM_SRC  register-write enable of each forwarding source.
REQ-010 src_rd  in  NUM_SRC*REG_AW  destination register of each forwarding source.
REQ-011 rs_id  in  NUM_RS*REG_AW  source registers of the instruction in ID.
REQ-012 id_valid  in  1  the ID slot holds a real instruction.
REQ-013 ex_is_load  in  1  the instruction in EX is a load.
REQ-014 ex_rd  in  REG_AW  destination register of the instruction in EX.
REQ-015 flush  in  1  branch redirect; kills the ID instruction.
REQ-016 fwd_sel  out  NUM_RS*SELW  per-port select: 0 = register file, k = source k-1.
REQ-017 stall  out  1  freeze PC and IF/ID, and insert a bubble into ID/EX.

Function
REQ-018 fwd_sel port p SHALL select the lowest-index source s where src_we[s]=1, src_rd[s]!=0 and src_rd[s]=rs_ex[p]; the result is s+1.
REQ-019 fwd_sel port p SHALL be 0 when no source matches, and SHALL be 0 whenever rs_ex[p]=0.
REQ-020 fwd_sel SHALL be purely combinational, with zero-cycle latency.
REQ-021 Hazard condition: id_valid=1, ex_is_load=1, ex_rd!=0, ex_rd equals any rs_id port, and state is IDLE.
REQ-022 FSM states SHALL be IDLE and HOLD, with a 4-bit counter cnt.
REQ-023 In IDLE with the hazard condition, stall SHALL be 1 in that same cycle.
REQ-024 In that case, if LOAD_LAT>1, the next state SHALL be HOLD with cnt=LOAD_LAT-1; otherwise the FSM SHALL remain in IDLE.
REQ-025 In HOLD, stall SHALL be 1 and cnt SHALL decrement each cycle; when cnt=1 the next state SHALL be IDLE.
REQ-026 Total stall length per hazard SHALL equal exactly LOAD_LAT cycles.
REQ-027 flush=1 SHALL force stall=0 in the same cycle and next state IDLE, overriding both the hazard condition and HOLD.
REQ-028 A new hazard SHALL NOT be evaluated while in HOLD; it is evaluated again on the first IDLE cycle.
REQ-029 The hazard condition SHALL NOT depend on rs_ex or src_*; only ID-against-EX is compared.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state IDLE, cnt=0 and stall=0; fwd_sel follows its inputs during reset.
REQ-031 Deassertion of rst_n mid-HOLD SHALL resume in IDLE with no residual stall.

Configuration
REQ-032 With FWD_STATS_EN defined, the block SHALL add output stall_cycles[31:0], counting cycles with stall=1.
REQ-033 With FWD_STATS_EN defined, the block SHALL add output fwd_events[31:0], counting cycles with any nonzero fwd_sel.
REQ-034 Both counters SHALL saturate at all ones and reset to 0.
REQ-035 Without FWD_STATS_EN, the counter ports and logic SHALL be absent and all other behaviour identical.

Structure
REQ-036 Package fwd_pkg SHALL hold the FSM state enum (IDLE, HOLD) and the fwd_sel encoding constant FWD_RF=0.
REQ-037 One sub-module, fwd_port_sel, SHALL implement the per-port priority match; it is instantiated NUM_RS times.

Verification
REQ-038 src_we=2'b11, src_rd={5'd3,5'd3}, rs_ex port0=3 -> fwd_sel port0=1 (youngest source wins).
REQ-039 src_we=2'b10, src_rd[1]=7, rs_ex port1=7 -> fwd_sel port1=2; with rs_ex port1=0 and src_rd[1]=0 -> fwd_sel port1=0.
REQ-040 LOAD_LAT=3, ex_is_load=1, ex_rd=4, rs_id port0=4, id_valid=1 -> stall high exactly 3 consecutive cycles, then low.
REQ-041 LOAD_LAT=3, flush=1 on the second stall cycle -> stall low that cycle and the FSM in IDLE the next cycle.
REQ-042 rst_n pulled low mid-HOLD -> stall=0 immediately; with FWD_STATS_EN, stall_cycles stops counting and reads 0 after reset.
REQ-043 ex_rd=0 with a matching load, or id_valid=0 -> stall never asserts.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding/hazard unit.
// Holds the stall FSM state encoding and the fwd_sel register-file code.
package fwd_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } fsm_state_e;

    localparam int FWD_RF = 0;

    function automatic int sel_w(input int num_src);
        return $clog2(num_src + 1);
    endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// Priority match of one EX source register against all forwarding sources.
// Purely combinational; lowest source index (youngest) wins, r0 never forwards.
module fwd_port_sel
    import fwd_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    localparam int SELW   = sel_w(NUM_SRC)
) (
    input  logic [REG_AW-1:0]         rs,
    input  logic [NUM_SRC-1:0]        src_we,
    input  logic [NUM_SRC*REG_AW-1:0] src_rd,
    output logic [SELW-1:0]           sel
);

    always_comb begin
        sel = SELW'(FWD_RF);
        // Walk oldest to youngest so the youngest match is the last one written.
        for (int s = NUM_SRC - 1; s >= 0; s--) begin
            if (src_we[s] && (src_rd[s*REG_AW +: REG_AW] != '0) &&
                (src_rd[s*REG_AW +: REG_AW] == rs)) begin
                sel = SELW'(s + 1);
            end
        end
        if (rs == '0) begin
            sel = SELW'(FWD_RF);
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// Operand forwarding selects (zero latency) plus load-use stall FSM (LOAD_LAT cycles).
// flush kills the stall at once; FWD_STATS_EN adds saturating stall/forward counters.
module forward_hazard_unit
    import fwd_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int NUM_RS   = 2,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    localparam int SELW    = sel_w(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_RS*REG_AW-1:0]  rs_ex,
    input  logic [NUM_SRC-1:0]        src_we,
    input  logic [NUM_SRC*REG_AW-1:0] src_rd,
    input  logic [NUM_RS*REG_AW-1:0]  rs_id,
    input  logic                      id_valid,
    input  logic                      ex_is_load,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic                      flush,
    output logic [NUM_RS*SELW-1:0]    fwd_sel,
    output logic                      stall
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]               stall_cycles,
    output logic [31:0]               fwd_events
`endif
);

    for (genvar p = 0; p < NUM_RS; p++) begin : g_port
        fwd_port_sel #(
            .NUM_SRC (NUM_SRC),
            .REG_AW  (REG_AW)
        ) u_sel (
            .rs     (rs_ex[p*REG_AW +: REG_AW]),
            .src_we (src_we),
            .src_rd (src_rd),
            .sel    (fwd_sel[p*SELW +: SELW])
        );
    end

    fsm_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       id_match;
    logic       hazard;
    logic       stall_raw;

    always_comb begin
        id_match = 1'b0;
        for (int p = 0; p < NUM_RS; p++) begin
            if (rs_id[p*REG_AW +: REG_AW] == ex_rd) begin
                id_match = 1'b1;
            end
        end
    end

    assign hazard = id_valid && ex_is_load && (ex_rd != '0) && id_match &&
                    (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hazard) begin
                        stall_raw = 1'b1;
                        // The IDLE cycle is the first stall cycle; HOLD covers the rest.
                        if (LOAD_LAT > 1) begin
                            state_d = HOLD;
                            cnt_d   = 4'(LOAD_LAT - 1);
                        end
                    end
                end
                HOLD: begin
                    stall_raw = 1'b1;
                    cnt_d     = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Reset must mask the combinational stall even while a hazard is presented.
    assign stall = stall_raw & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef FWD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] fwd_events_q, fwd_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        fwd_events_d   = fwd_events_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if ((|fwd_sel) && (fwd_events_q != '1)) begin
            fwd_events_d = fwd_events_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= 32'd0;
            fwd_events_q   <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            fwd_events_q   <= fwd_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign fwd_events   = fwd_events_q;
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit: table of combinational vectors plus
// hand-written load-use, flush and mid-HOLD reset sequences (LOAD_LAT=3).
module tb_forward_hazard_unit;

    localparam int NUM_SRC  = 2;
    localparam int NUM_RS   = 2;
    localparam int REG_AW   = 5;
    localparam int LOAD_LAT = 3;
    localparam int SELW     = 2;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_RS*REG_AW-1:0]  rs_ex;
    logic [NUM_SRC-1:0]        src_we;
    logic [NUM_SRC*REG_AW-1:0] src_rd;
    logic [NUM_RS*REG_AW-1:0]  rs_id;
    logic                      id_valid;
    logic                      ex_is_load;
    logic [REG_AW-1:0]         ex_rd;
    logic                      flush;
    logic [NUM_RS*SELW-1:0]    fwd_sel;
    logic                      stall;
`ifdef FWD_STATS_EN
    logic [31:0]               stall_cycles;
    logic [31:0]               fwd_events;
`endif

    forward_hazard_unit #(
        .NUM_SRC  (NUM_SRC),
        .NUM_RS   (NUM_RS),
        .REG_AW   (REG_AW),
        .LOAD_LAT (LOAD_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs_ex        (rs_ex),
        .src_we       (src_we),
        .src_rd       (src_rd),
        .rs_id        (rs_id),
        .id_valid     (id_valid),
        .ex_is_load   (ex_is_load),
        .ex_rd        (ex_rd),
        .flush        (flush),
        .fwd_sel      (fwd_sel),
        .stall        (stall)
`ifdef FWD_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .fwd_events   (fwd_events)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] we;
        logic [9:0] s_rd;
        logic [9:0] r_ex;
        logic [9:0] r_id;
        logic       idv;
        logic       ld;
        logic [4:0] erd;
        logic [3:0] exp_fwd;
        logic       exp_stall;
    } vec_t;

    vec_t vecs[12];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs_ex = '0; src_we = '0; src_rd = '0; rs_id = '0;
        id_valid = 1'b0; ex_is_load = 1'b0; ex_rd = '0; flush = 1'b0;
    endtask

    // Load writing r4 in EX, instruction in ID reads r4 on port 0.
    task automatic load_use();
        id_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd4; rs_id = {5'd0, 5'd4};
    endtask

    initial begin
        //            we     src_rd{s1,s0}    rs_ex{p1,p0}     rs_id{p1,p0}   idv   ld    erd    fwd       stall
        vecs[0]  = '{2'b11, {5'd3,  5'd3},  {5'd0,  5'd3},  {5'd0, 5'd0}, 1'b0, 1'b0, 5'd0, 4'b0001, 1'b0};
        vecs[1]  = '{2'b10, {5'd7,  5'd0},  {5'd7,  5'd0},  {5'd0, 5'd0}, 1'b0, 1'b0, 5'd0, 4'b1000, 1'b0};
        vecs[2]  = '{2'b10, {5'd0,  5'd0},  {5'd0,  5'd0},  {5'd0, 5'd0}, 1'b0, 1'b0, 5'd0, 4'b0000, 1'b0};
        vecs[3]  = '{2'b01, {5'd9,  5'd5},  {5'd9,  5'd5},  {5'd0, 5'd0}, 1'b0, 1'b0, 5'd0, 4'b0001, 1'b0};
        vecs[4]  = '{2'b11, {5'd9,  5'd5},  {5'd5,  5'd9},  {5'd0, 5'd0}, 1'b0, 1'b0, 5'd0, 4'b0110, 1'b0};
        vecs[5]  = '{2'b11, {5'd12, 5'd12}, {5'd12, 5'd12}, {5'd0, 5'd0}, 1'b0, 1'b0, 5'd0, 4'b0101, 1'b0};
        vecs[6]  = '{2'b00, {5'd4,  5'd4},  {5'd4,  5'd4},  {5'd0, 5'd0}, 1'b0, 1'b0, 5'd0, 4'b0000, 1'b0};
        vecs[7]  = '{2'b10, {5'd31, 5'd30}, {5'd30, 5'd31}, {5'd0, 5'd0}, 1'b0, 1'b0, 5'd0, 4'b0010, 1'b0};
        vecs[8]  = '{2'b11, {5'd6,  5'd0},  {5'd0,  5'd6},  {5'd0, 5'd0}, 1'b0, 1'b0, 5'd0, 4'b0010, 1'b0};
        vecs[9]  = '{2'b00, {5'd0,  5'd0},  {5'd0,  5'd0},  {5'd0, 5'd4}, 1'b0, 1'b1, 5'd4, 4'b0000, 1'b0};
        vecs[10] = '{2'b00, {5'd0,  5'd0},  {5'd0,  5'd0},  {5'd0, 5'd0}, 1'b1, 1'b1, 5'd0, 4'b0000, 1'b0};
        vecs[11] = '{2'b00, {5'd0,  5'd0},  {5'd0,  5'd0},  {5'd4, 5'd0}, 1'b1, 1'b0, 5'd4, 4'b0000, 1'b0};

        idle_inputs();
        rst_n = 1'b0;
        #1;
        load_use();
        #2;
        check("reset_stall_masked", 32'(stall), 32'd0);
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #3;
        check("post_reset_stall", 32'(stall), 32'd0);
`ifdef FWD_STATS_EN
        check("reset_stall_cycles", stall_cycles, 32'd0);
        check("reset_fwd_events", fwd_events, 32'd0);
`endif

        for (int i = 0; i < 12; i++) begin
            tick();
            src_we = vecs[i].we; src_rd = vecs[i].s_rd; rs_ex = vecs[i].r_ex;
            rs_id = vecs[i].r_id; id_valid = vecs[i].idv; ex_is_load = vecs[i].ld;
            ex_rd = vecs[i].erd; flush = 1'b0;
            #3;
            check($sformatf("vec%0d_fwd_sel", i), 32'(fwd_sel), 32'(vecs[i].exp_fwd));
            check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
        end

        // Load-use: hazard kept visible through HOLD must not restart the count.
        tick(); idle_inputs(); #3;
`ifdef FWD_STATS_EN
        check("stats_before_lu", stall_cycles, 32'd0);
`endif
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c < 3) load_use(); else idle_inputs();
            #3;
            check($sformatf("lu_cycle%0d_stall", c), 32'(stall), (c < 3) ? 32'd1 : 32'd0);
        end
`ifdef FWD_STATS_EN
        check("stats_after_lu", stall_cycles, 32'd3);
`endif

        // Flush on second stall cycle, then confirm a fresh full-length stall.
        tick(); load_use(); #3;
        check("fl_first_stall", 32'(stall), 32'd1);
        tick(); idle_inputs(); flush = 1'b1; #3;
        check("fl_flush_cycle_stall", 32'(stall), 32'd0);
        tick(); idle_inputs(); #3;
        check("fl_idle_after_flush", 32'(stall), 32'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            if (c == 0) load_use(); else idle_inputs();
            #3;
            check($sformatf("fl_restart%0d_stall", c), 32'(stall), (c < 3) ? 32'd1 : 32'd0);
        end

        // Reset pulled mid-HOLD.
        tick(); load_use(); #3;
        check("rst_first_stall", 32'(stall), 32'd1);
        tick(); idle_inputs(); #1;
        check("rst_hold_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #2;
        check("rst_async_stall", 32'(stall), 32'd0);
        tick(); #3;
        check("rst_held_stall", 32'(stall), 32'd0);
        tick(); rst_n = 1'b1; #3;
        check("rst_resume_stall0", 32'(stall), 32'd0);
`ifdef FWD_STATS_EN
        check("rst_stall_cycles", stall_cycles, 32'd0);
`endif
        tick(); #3;
        check("rst_resume_stall1", 32'(stall), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
